// File: rtl/io_bus_arbiter.sv
// Two-master arbiter for the io peripheral bus: CPU core (m0) and UART loader (m1).
// Alternating grant on ties, one transfer per grant, forced abort after TIMEOUT wait cycles.
module io_bus_arbiter #(
   parameter int unsigned TIMEOUT = 15
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        m0_stb_i,
   input  logic        m0_we_i,
   input  logic [15:0] m0_addr_i,
   input  logic [15:0] m0_dat_i,
   output logic        m0_ack_o,
   output logic        m0_err_o,
   input  logic        m1_stb_i,
   input  logic        m1_we_i,
   input  logic [15:0] m1_addr_i,
   input  logic [15:0] m1_dat_i,
   output logic        m1_ack_o,
   output logic        m1_err_o,
   output logic [15:0] m_dat_o,
   output logic        s_stb_o,
   output logic        s_we_o,
   output logic [15:0] s_addr_o,
   output logic [15:0] s_dat_o,
   input  logic        s_ack_i,
   input  logic [15:0] s_dat_i,
   output logic [1:0]  grant_o,
   output logic [5:0]  timeout_cnt_o
);

   // State encoding doubles as the one-hot grant vector.
   localparam logic [1:0] IDLE = 2'b00;
   localparam logic [1:0] GNT0 = 2'b01;
   localparam logic [1:0] GNT1 = 2'b10;

   localparam logic [5:0] CNT_LAST = 6'(TIMEOUT - 1);

   logic [1:0]  state;
   logic [1:0]  state_nxt;
   logic        last;
   logic        last_nxt;
   logic [5:0]  cnt;
   logic [5:0]  cnt_nxt;

   logic        sel_stb;
   logic        sel_we;
   logic [15:0] sel_addr;
   logic [15:0] sel_dat;
   logic        cyc_ack;
   logic        cyc_err;

   always_comb begin
      sel_stb  = 1'b0;
      sel_we   = 1'b0;
      sel_addr = '0;
      sel_dat  = '0;
      case (state)
         GNT0: begin
            sel_stb  = m0_stb_i;
            sel_we   = m0_we_i;
            sel_addr = m0_addr_i;
            sel_dat  = m0_dat_i;
         end
         GNT1: begin
            sel_stb  = m1_stb_i;
            sel_we   = m1_we_i;
            sel_addr = m1_addr_i;
            sel_dat  = m1_dat_i;
         end
         default: ;
      endcase
   end

   // Acknowledge wins over a timeout landing in the same cycle.
   assign cyc_ack = sel_stb & s_ack_i;
   assign cyc_err = sel_stb & ~s_ack_i & (cnt == CNT_LAST);

   assign s_stb_o       = sel_stb;
   assign s_we_o        = sel_we;
   assign s_addr_o      = sel_addr;
   assign s_dat_o       = sel_dat;
   assign m_dat_o       = s_dat_i;
   assign grant_o       = state;
   assign timeout_cnt_o = cnt;

   assign m0_ack_o = (state == GNT0) & cyc_ack;
   assign m0_err_o = (state == GNT0) & cyc_err;
   assign m1_ack_o = (state == GNT1) & cyc_ack;
   assign m1_err_o = (state == GNT1) & cyc_err;

   always_comb begin
      state_nxt = state;
      last_nxt  = last;
      cnt_nxt   = cnt;
      case (state)
         IDLE: begin
            cnt_nxt = '0;
            if (m0_stb_i && m1_stb_i)
               state_nxt = last ? GNT0 : GNT1;
            else if (m0_stb_i)
               state_nxt = GNT0;
            else if (m1_stb_i)
               state_nxt = GNT1;
         end
         GNT0, GNT1: begin
            // Withdrawal, completion and abort all end the grant the same way.
            if (!sel_stb || cyc_ack || cyc_err) begin
               state_nxt = IDLE;
               last_nxt  = (state == GNT1);
               cnt_nxt   = '0;
            end else begin
               cnt_nxt = cnt + 6'd1;
            end
         end
         default: begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
         end
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state <= IDLE;
         last  <= 1'b1;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         last  <= last_nxt;
         cnt   <= cnt_nxt;
      end
   end

endmodule

// File: tb/tb_io_bus_arbiter.sv
// Bench for io_bus_arbiter: directed vectors, expected responses queued by stimulus
// and matched by an independent monitor on every ack/err pulse.
module tb_io_bus_arbiter;

   logic        clk_i;
   logic        rst_i;
   logic        m0_stb_i, m0_we_i;
   logic [15:0] m0_addr_i, m0_dat_i;
   logic        m0_ack_o, m0_err_o;
   logic        m1_stb_i, m1_we_i;
   logic [15:0] m1_addr_i, m1_dat_i;
   logic        m1_ack_o, m1_err_o;
   logic [15:0] m_dat_o;
   logic        s_stb_o, s_we_o;
   logic [15:0] s_addr_o, s_dat_o;
   logic        s_ack_i;
   logic [15:0] s_dat_i;
   logic [1:0]  grant_o;
   logic [5:0]  timeout_cnt_o;

   io_bus_arbiter #(.TIMEOUT(15)) dut (
      .clk_i(clk_i), .rst_i(rst_i),
      .m0_stb_i(m0_stb_i), .m0_we_i(m0_we_i), .m0_addr_i(m0_addr_i), .m0_dat_i(m0_dat_i),
      .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o),
      .m1_stb_i(m1_stb_i), .m1_we_i(m1_we_i), .m1_addr_i(m1_addr_i), .m1_dat_i(m1_dat_i),
      .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o),
      .m_dat_o(m_dat_o),
      .s_stb_o(s_stb_o), .s_we_o(s_we_o), .s_addr_o(s_addr_o), .s_dat_o(s_dat_o),
      .s_ack_i(s_ack_i), .s_dat_i(s_dat_i),
      .grant_o(grant_o), .timeout_cnt_o(timeout_cnt_o)
   );

   typedef struct {
      logic        mst;
      logic        err;
      logic        we;
      logic [15:0] addr;
      logic [15:0] wdat;
      logic [15:0] rdata;
      logic [5:0]  cnt;
   } exp_t;

   exp_t sb[$];
   int   n_tests = 0;
   int   n_fail  = 0;

   initial begin
      clk_i = 1'b0;
      forever #5 clk_i = ~clk_i;
   end

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h required %h", name, act, exp);
      end
   endtask

   task automatic push(input logic mst, input logic err, input logic [5:0] cnt);
      exp_t e;
      e.mst   = mst;
      e.err   = err;
      e.we    = mst ? m1_we_i : m0_we_i;
      e.addr  = mst ? m1_addr_i : m0_addr_i;
      e.wdat  = mst ? m1_dat_i : m0_dat_i;
      e.rdata = s_dat_i;
      e.cnt   = cnt;
      sb.push_back(e);
   endtask

   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   // Monitor: every ack/err pulse must match the oldest queued expectation.
   always @(negedge clk_i) begin
      logic [3:0] hits;
      logic [3:0] ehits;
      exp_t       e;
      if (!rst_i) begin
         hits = {m1_err_o, m1_ack_o, m0_err_o, m0_ack_o};
         if (hits != 4'b0000) begin
            if (sb.size() == 0) begin
               check("unexpected_resp", {12'h000, hits}, 16'h0000);
            end else begin
               e = sb.pop_front();
               ehits = e.mst ? (e.err ? 4'b1000 : 4'b0100) : (e.err ? 4'b0010 : 4'b0001);
               check("resp_kind", {12'h000, hits}, {12'h000, ehits});
               check("resp_addr", s_addr_o, e.addr);
               check("resp_wdat", s_dat_o, e.wdat);
               check("resp_we", {15'h0, s_we_o}, {15'h0, e.we});
               check("resp_rdata", m_dat_o, e.rdata);
               check("resp_cnt", {10'h0, timeout_cnt_o}, {10'h0, e.cnt});
            end
         end
      end
   end

   task automatic idle_inputs();
      m0_stb_i = 1'b0; m0_we_i = 1'b0; m0_addr_i = '0; m0_dat_i = '0;
      m1_stb_i = 1'b0; m1_we_i = 1'b0; m1_addr_i = '0; m1_dat_i = '0;
      s_ack_i  = 1'b0; s_dat_i = '0;
   endtask

   task automatic do_reset();
      rst_i = 1'b1;
      repeat (2) @(posedge clk_i);
      #1 rst_i = 1'b0;
   endtask

   // Both masters request continuously while the slave acks at once: grants alternate
   // starting from 'first', with one IDLE cycle between transfers.
   task automatic tie_run(input int n, input logic first);
      m0_stb_i = 1'b1; m0_we_i = 1'b1; m0_addr_i = 16'h0010; m0_dat_i = 16'h1111;
      m1_stb_i = 1'b1; m1_we_i = 1'b0; m1_addr_i = 16'h0020; m1_dat_i = 16'h2222;
      s_dat_i  = 16'h5A5A;
      s_ack_i  = 1'b1;
      for (int k = 0; k < n; k++) push(first ^ k[0], 1'b0, 6'd0);
      #1;
      check("tie_idle_grant", {14'h0, grant_o}, 16'h0000);
      check("tie_idle_noack", {12'h0, m1_err_o, m1_ack_o, m0_err_o, m0_ack_o}, 16'h0000);
      for (int c = 0; c < 2 * n; c++) begin
         int unsigned k;
         logic        m;
         logic [1:0]  eg;
         step();
         k  = c / 2;
         m  = first ^ k[0];
         eg = (c % 2 == 0) ? (m ? 2'b10 : 2'b01) : 2'b00;
         check("tie_grant", {14'h0, grant_o}, {14'h0, eg});
      end
      idle_inputs();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout required completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      idle_inputs();
      rst_i = 1'b1;
      // Reset must hold outputs quiet even with live requests and acks.
      m0_stb_i = 1'b1; m0_addr_i = 16'hA5A5; m0_dat_i = 16'h5A5A; m0_we_i = 1'b1;
      s_ack_i  = 1'b1;
      repeat (3) @(posedge clk_i);
      #1;
      check("rst_grant", {14'h0, grant_o}, 16'h0000);
      check("rst_stb_we", {14'h0, s_stb_o, s_we_o}, 16'h0000);
      check("rst_addr", s_addr_o, 16'h0000);
      check("rst_dat", s_dat_o, 16'h0000);
      check("rst_cnt", {10'h0, timeout_cnt_o}, 16'h0000);
      check("rst_ackerr", {12'h0, m1_err_o, m1_ack_o, m0_err_o, m0_ack_o}, 16'h0000);
      idle_inputs();
      @(posedge clk_i);
      #1 rst_i = 1'b0;

      // Single write, slave acks on the third granted cycle.
      m0_stb_i = 1'b1; m0_we_i = 1'b1; m0_addr_i = 16'h0004; m0_dat_i = 16'hBEEF;
      step();
      check("wr_grant", {14'h0, grant_o}, 16'h0001);
      check("wr_stb", {15'h0, s_stb_o}, 16'h0001);
      check("wr_addr", s_addr_o, 16'h0004);
      check("wr_dat", s_dat_o, 16'hBEEF);
      step();
      check("wr_cnt1", {10'h0, timeout_cnt_o}, 16'h0001);
      step();
      push(1'b0, 1'b0, 6'd2);
      s_ack_i = 1'b1;
      step();
      idle_inputs();
      check("wr_grant_after", {14'h0, grant_o}, 16'h0000);

      // Read from m1.
      m1_stb_i = 1'b1; m1_we_i = 1'b0; m1_addr_i = 16'h0002;
      step();
      check("rd_grant", {14'h0, grant_o}, 16'h0002);
      s_dat_i = 16'h0180;
      s_ack_i = 1'b1;
      push(1'b1, 1'b0, 6'd0);
      #1;
      check("rd_mdat", m_dat_o, 16'h0180);
      check("rd_m0ack", {15'h0, m0_ack_o}, 16'h0000);
      step();
      idle_inputs();

      // Tie right after reset: m0 first.
      do_reset();
      tie_run(4, 1'b0);

      // Timeout on m0 with m1 pending; m1 served afterwards.
      m0_stb_i = 1'b1; m0_we_i = 1'b0; m0_addr_i = 16'h0040;
      m1_stb_i = 1'b1; m1_we_i = 1'b1; m1_addr_i = 16'h0050; m1_dat_i = 16'hCAFE;
      s_dat_i  = 16'h1234;
      push(1'b0, 1'b1, 6'd14);
      for (int i = 0; i < 15; i++) begin
         step();
         check("to_grant", {14'h0, grant_o}, 16'h0001);
         check("to_cnt", {10'h0, timeout_cnt_o}, 16'(i));
      end
      step();
      check("to_idle", {14'h0, grant_o}, 16'h0000);
      check("to_idle_cnt", {10'h0, timeout_cnt_o}, 16'h0000);
      step();
      check("to_m1_grant", {14'h0, grant_o}, 16'h0002);
      m0_stb_i = 1'b0;
      push(1'b1, 1'b0, 6'd0);
      s_ack_i = 1'b1;
      step();
      idle_inputs();
      check("to_m1_done", {14'h0, grant_o}, 16'h0000);

      // Ack arriving on the timeout cycle wins.
      m0_stb_i = 1'b1; m0_we_i = 1'b1; m0_addr_i = 16'h0060; m0_dat_i = 16'h7777;
      for (int i = 0; i < 15; i++) begin
         step();
         check("ackto_cnt", {10'h0, timeout_cnt_o}, 16'(i));
      end
      push(1'b0, 1'b0, 6'd14);
      s_ack_i = 1'b1;
      step();
      idle_inputs();
      check("ackto_idle", {14'h0, grant_o}, 16'h0000);

      // m0 withdraws while granted: silent return to IDLE, m0 counted as last.
      m0_stb_i = 1'b1; m0_addr_i = 16'h0008;
      step();
      check("wd_grant", {14'h0, grant_o}, 16'h0001);
      m0_stb_i = 1'b0;
      #1;
      check("wd_stb", {15'h0, s_stb_o}, 16'h0000);
      step();
      check("wd_idle", {14'h0, grant_o}, 16'h0000);
      tie_run(2, 1'b1);

      // Reset while m1 holds the bus.
      m1_stb_i = 1'b1; m1_we_i = 1'b1; m1_addr_i = 16'h0070; m1_dat_i = 16'h9999;
      step();
      check("rg_grant", {14'h0, grant_o}, 16'h0002);
      check("rg_stb", {15'h0, s_stb_o}, 16'h0001);
      #2;
      rst_i   = 1'b1;
      s_ack_i = 1'b1;
      #1;
      check("rg_stb_drop", {15'h0, s_stb_o}, 16'h0000);
      check("rg_grant_drop", {14'h0, grant_o}, 16'h0000);
      check("rg_m1_quiet", {14'h0, m1_err_o, m1_ack_o}, 16'h0000);
      @(posedge clk_i);
      #1;
      rst_i = 1'b0;
      idle_inputs();
      tie_run(2, 1'b0);

      repeat (3) step();
      check("sb_drained", 16'(sb.size()), 16'h0000);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
